// File: rtl/bpsk_phase_generator_if.sv
// bpsk_phase_generator_if: valid/ready bit stream into the BPSK phase generator
interface bpsk_phase_generator_if;
  logic bit_data;
  logic bit_valid;
  logic bit_ready;
  modport master (output bit_data, output bit_valid, input bit_ready);
  modport slave (input bit_data, input bit_valid, output bit_ready);
endinterface

// File: rtl/bpsk_phase_generator.sv
// bpsk_phase_generator: BPSK-offset carrier phase index for a sine wave-table
module bpsk_phase_generator #(
  parameter int DATA_WIDTH = 12,
  parameter int SINE_RESOLUTION = 6,
  parameter int CLKS_PER_SAMPLE = 4,
  parameter int CYCLES_PER_BIT = 2
) (
  input  logic clk,
  input  logic reset,
  bpsk_phase_generator_if.slave s,
  output logic [DATA_WIDTH-1:0] phase,
  output logic sample_strobe,
  output logic symbol_start,
  output logic busy
);
  localparam int PERIOD = 2 * SINE_RESOLUTION;
  localparam int DW = CLKS_PER_SAMPLE > 1 ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam int CW = $clog2(PERIOD);
  localparam int YW = CYCLES_PER_BIT > 1 ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLKS_PER_SAMPLE - 1);
  localparam logic [CW-1:0] CAR_MAX = CW'(PERIOD - 1);
  localparam logic [YW-1:0] CYC_MAX = YW'(CYCLES_PER_BIT - 1);
  localparam logic [DATA_WIDTH:0] HALF = (DATA_WIDTH + 1)'(SINE_RESOLUTION);
  localparam logic [DATA_WIDTH:0] FULL = (DATA_WIDTH + 1)'(PERIOD);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic hold_full, hold_bit, cur_bit, cur_n;
  logic [DW-1:0] div_cnt, div_n;
  logic [CW-1:0] car_idx, car_n;
  logic [YW-1:0] cyc_cnt, cyc_n;
  logic div_wrap, car_wrap, cyc_wrap, at_end, consume, accept;
  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH-1:0] phase_n;
  // next-state: counter stepping, bit hand-off at symbol boundaries, phase folding
  always_comb begin
    div_wrap = div_cnt == DIV_MAX;
    car_wrap = car_idx == CAR_MAX;
    cyc_wrap = cyc_cnt == CYC_MAX;
    at_end = state == RUN && div_wrap && car_wrap && cyc_wrap;
    consume = hold_full && (state == IDLE || at_end);
    s.bit_ready = !hold_full || consume;
    accept = s.bit_valid && s.bit_ready;
    state_n = consume ? RUN : at_end ? IDLE : state;
    cur_n = consume ? hold_bit : cur_bit;
    div_n = (consume || at_end || state != RUN || div_wrap) ? '0 : div_cnt + 1'b1;
    car_n = (consume || at_end) ? '0 : (state == RUN && div_wrap) ? (car_wrap ? '0 : car_idx + 1'b1) : car_idx;
    cyc_n = (consume || at_end) ? '0 : (state == RUN && div_wrap && car_wrap) ? (cyc_wrap ? '0 : cyc_cnt + 1'b1) : cyc_cnt;
    sum = (DATA_WIDTH + 1)'(car_n) + (cur_n ? HALF : '0);
    phase_n = state_n == RUN ? DATA_WIDTH'(sum >= FULL ? sum - FULL : sum) : '0;
  end
  // state, holding register, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hold_full <= 1'b0;
      hold_bit <= 1'b0;
      cur_bit <= 1'b0;
      div_cnt <= '0;
      car_idx <= '0;
      cyc_cnt <= '0;
      phase <= '0;
      sample_strobe <= 1'b0;
      symbol_start <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      hold_full <= accept || (hold_full && !consume);
      hold_bit <= accept ? s.bit_data : hold_bit;
      cur_bit <= cur_n;
      div_cnt <= div_n;
      car_idx <= car_n;
      cyc_cnt <= cyc_n;
      phase <= phase_n;
      sample_strobe <= state_n == RUN && div_n == '0;
      symbol_start <= consume;
      busy <= state_n == RUN;
    end
  end
endmodule

// File: tb/tb_bpsk_phase_generator.sv
// tb_bpsk_phase_generator: directed checks of the BPSK phase generator
module tb_bpsk_phase_generator;
  logic clk = 1'b0;
  logic reset;
  int vec = 0;
  int errs = 0;
  logic [11:0] a_phase, b_phase;
  logic a_ss, a_sym, a_busy, b_ss, b_sym, b_busy;
  logic bits [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  bpsk_phase_generator_if ia ();
  bpsk_phase_generator_if ib ();
  bpsk_phase_generator #(.DATA_WIDTH(12), .SINE_RESOLUTION(6), .CLKS_PER_SAMPLE(1), .CYCLES_PER_BIT(1)) dut_a (
    .clk(clk), .reset(reset), .s(ia.slave), .phase(a_phase), .sample_strobe(a_ss), .symbol_start(a_sym), .busy(a_busy));
  bpsk_phase_generator dut_b (
    .clk(clk), .reset(reset), .s(ib.slave), .phase(b_phase), .sample_strobe(b_ss), .symbol_start(b_sym), .busy(b_busy));
  // free-running clock
  always #5 clk = ~clk;
  // hard stop if the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog timeout vectors=%0d", vec);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic run_a(input logic b);
    ia.bit_data = b;
    ia.bit_valid = 1'b1;
    @(posedge clk); #1;
    ia.bit_valid = 1'b0;
    chk("a_idle_after_accept", a_busy, 0);
    chk("a_ready_on_consume", ia.bit_ready, 1);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk("a_phase", a_phase, (k + (b ? 6 : 0)) % 12);
      chk("a_sym", a_sym, k == 0);
      chk("a_strobe", a_ss, 1);
      chk("a_busy", a_busy, 1);
    end
    @(posedge clk); #1;
    chk("a_end_busy", a_busy, 0);
    chk("a_end_phase", a_phase, 0);
    chk("a_end_strobe", a_ss, 0);
  endtask
  initial begin
    int t;
    int w;
    int j;
    int r;
    reset = 1'b1;
    ia.bit_valid = 1'b1;
    ia.bit_data = 1'b1;
    ib.bit_valid = 1'b1;
    ib.bit_data = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_a_phase", a_phase, 0);
      chk("rst_a_busy", a_busy, 0);
      chk("rst_a_strobe", a_ss, 0);
      chk("rst_a_sym", a_sym, 0);
      chk("rst_b_phase", b_phase, 0);
      chk("rst_b_busy", b_busy, 0);
    end
    reset = 1'b0;
    ia.bit_valid = 1'b0;
    ib.bit_valid = 1'b0;
    @(posedge clk); #1;
    chk("rel_a_ready", ia.bit_ready, 1);
    chk("rel_b_ready", ib.bit_ready, 1);
    chk("rel_a_busy", a_busy, 0);
    @(posedge clk); #1;
    chk("rel_a_no_xfer", a_busy, 0);
    chk("rel_b_no_xfer", b_busy, 0);
    run_a(1'b0);
    run_a(1'b1);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          ib.bit_data = bits[i];
          ib.bit_valid = 1'b1;
          t = 0;
          @(negedge clk);
          while (!ib.bit_ready && t < 500) begin
            @(negedge clk);
            t++;
          end
          @(posedge clk); #1;
        end
        ib.bit_valid = 1'b0;
      end
      begin
        w = 0;
        do begin
          @(posedge clk); #1;
          w++;
        end while (!b_sym && w < 50);
        chk("b_first_sym", b_sym, 1);
        for (int c = 0; c < 384; c++) begin
          if (c > 0) begin
            @(posedge clk); #1;
          end
          j = c / 96;
          r = c % 96;
          chk("b_phase", b_phase, ((r / 4) % 12 + (bits[j] ? 6 : 0)) % 12);
          chk("b_sym", b_sym, r == 0);
          chk("b_strobe", b_ss, r % 4 == 0);
          chk("b_busy", b_busy, 1);
          if (r == 50) chk("b_ready_mid", ib.bit_ready, j == 3);
          if (r == 95) chk("b_ready_end", ib.bit_ready, 1);
        end
        @(posedge clk); #1;
        chk("b_end_busy", b_busy, 0);
        chk("b_end_phase", b_phase, 0);
      end
    join
    ib.bit_data = 1'b1;
    ib.bit_valid = 1'b1;
    @(posedge clk); #1;
    ib.bit_data = 1'b0;
    @(posedge clk); #1;
    ib.bit_valid = 1'b0;
    chk("d_run_start", b_sym, 1);
    chk("d_run_phase", b_phase, 6);
    repeat (40) begin
      @(posedge clk); #1;
    end
    chk("d_ready_held", ib.bit_ready, 0);
    chk("d_phase_c40", b_phase, 10 % 12 + 6 > 11 ? (10 + 6) % 12 : 16);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("d_abort_busy", b_busy, 0);
    chk("d_abort_phase", b_phase, 0);
    chk("d_abort_ready", ib.bit_ready, 1);
    for (int k = 0; k < 120; k++) begin
      @(posedge clk); #1;
      chk("d_held_dropped", b_busy, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
